// File: rtl/mips_pkg.sv
// mips_pkg: shared funct codes, default datapath width and mul/div FSM states
package mips_pkg;
    localparam int DATA_W_DEF = 32;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MTHI  = 6'b010001;
    localparam logic [5:0] FN_MFLO  = 6'b010010;
    localparam logic [5:0] FN_MTLO  = 6'b010011;
    localparam logic [5:0] FN_MULT  = 6'b011000;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIV   = 6'b011010;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIX} md_state_e;
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational radix-2 step of shift-add multiply or restoring divide
//  i_div        1  selects divide (1) or multiply (0)
//  i_acc, i_q   W  partial {acc,q}: product {hi,lo} or {remainder, dividend/quotient}
//  i_b          W  multiplicand / divisor magnitude
//  o_acc, o_q   W  next {acc,q}
module muldiv_step #(
    parameter int W = 32
) (
    input  logic         i_div,
    input  logic [W-1:0] i_acc,
    input  logic [W-1:0] i_q,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_acc,
    output logic [W-1:0] o_q
);
    logic [W:0]   sum;
    logic [W:0]   shl;
    logic [W-1:0] diff;
    logic         ok;
    always_comb begin
        sum   = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_b} : '0);
        shl   = {i_acc, i_q[W-1]};
        // low W bits of the true difference; only used when it is non-negative
        diff  = shl[W-1:0] - i_b;
        ok    = shl >= {1'b0, i_b};
        o_acc = i_div ? (ok ? diff : shl[W-1:0]) : sum[W:1];
        o_q   = i_div ? {i_q[W-2:0], ok} : {sum[0], i_q[W-1:1]};
    end
endmodule

// File: rtl/alu_muldiv_unit.sv
// alu_muldiv_unit: iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with MFxx/MTxx and stall
//  i_clk, i_rst_n      clock, async active-low reset
//  i_valid, i_func     EX holds an R-type op and its funct field
//  i_rs, i_rt          operand A / operand B
//  i_flush             abort the in-flight op
//  o_busy, o_stall     op in flight; hold the requesting instruction
//  o_done              HI/LO written this cycle
//  o_hi, o_lo          HI/LO registers
module alu_muldiv_unit
    import mips_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int FUNC_W = 6,
    localparam int CNT_W = $clog2(DATA_W) + 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_valid,
    input  logic [FUNC_W-1:0] i_func,
    input  logic [DATA_W-1:0] i_rs,
    input  logic [DATA_W-1:0] i_rt,
    input  logic              i_flush,
    output logic              o_busy,
    output logic              o_stall,
    output logic              o_done,
    output logic [DATA_W-1:0] o_hi,
    output logic [DATA_W-1:0] o_lo
);
    md_state_e           state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   acc_q, acc_d, q_q, q_d, b_q, b_d, hi_q, hi_d, lo_q, lo_d;
    logic [DATA_W-1:0]   acc_s, q_s, mag_a, mag_b, fix_hi, fix_lo;
    logic [2*DATA_W-1:0] prod;
    logic                div_q, div_d, neg_q_q, neg_q_d, neg_r_q, neg_r_d;
    logic                idle, is_md, is_hilo, take, sgn, neg_a, neg_b;

    assign idle    = state_q == MD_IDLE;
    assign is_md   = i_func inside {FN_MULT, FN_MULTU, FN_DIV, FN_DIVU};
    assign is_hilo = is_md || (i_func inside {FN_MFHI, FN_MTHI, FN_MFLO, FN_MTLO});
    assign take    = idle && i_valid && !i_flush;
    // funct bit 0 marks the unsigned variants, bit 1 marks divide
    assign sgn     = !i_func[0];
    assign neg_a   = sgn && i_rs[DATA_W-1];
    assign neg_b   = sgn && i_rt[DATA_W-1];
    assign mag_a   = neg_a ? -i_rs : i_rs;
    assign mag_b   = neg_b ? -i_rt : i_rt;
    assign prod    = neg_q_q ? -{acc_q, q_q} : {acc_q, q_q};
    assign fix_hi  = div_q ? (neg_r_q ? -acc_q : acc_q) : prod[2*DATA_W-1:DATA_W];
    assign fix_lo  = div_q ? (neg_q_q ? -q_q : q_q) : prod[DATA_W-1:0];

    muldiv_step #(.W(DATA_W)) u_step (
        .i_div(div_q),
        .i_acc(acc_q),
        .i_q  (q_q),
        .i_b  (b_q),
        .o_acc(acc_s),
        .o_q  (q_s)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        q_d     = q_q;
        b_d     = b_q;
        div_d   = div_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            MD_IDLE: begin
                if (take && is_md) begin
                    state_d = MD_CALC;
                    cnt_d   = CNT_W'(DATA_W);
                    acc_d   = '0;
                    q_d     = mag_a;
                    b_d     = mag_b;
                    div_d   = i_func[1];
                    // a zero divisor keeps the all-ones quotient positive; the
                    // remainder then re-signs back to the raw dividend
                    neg_q_d = (neg_a ^ neg_b) && (!i_func[1] || (|i_rt));
                    neg_r_d = neg_a && i_func[1];
                end
                hi_d = (take && i_func == FN_MTHI) ? i_rs : hi_q;
                lo_d = (take && i_func == FN_MTLO) ? i_rs : lo_q;
            end
            MD_CALC: begin
                acc_d   = acc_s;
                q_d     = q_s;
                cnt_d   = cnt_q - CNT_W'(1);
                state_d = (cnt_q == CNT_W'(1)) ? MD_FIX : MD_CALC;
            end
            MD_FIX: begin
                state_d = MD_IDLE;
                hi_d    = fix_hi;
                lo_d    = fix_lo;
            end
            default: state_d = MD_IDLE;
        endcase
        if (i_flush && !idle) begin
            state_d = MD_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            b_q     <= '0;
            div_q   <= 1'b0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            b_q     <= b_d;
            div_q   <= div_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign o_busy  = !idle;
    assign o_stall = o_busy && i_valid && is_hilo;
    assign o_done  = state_q == MD_FIX && !i_flush;
    assign o_hi    = hi_q;
    assign o_lo    = lo_q;
endmodule

// File: tb/tb_alu_muldiv_unit.sv
// tb_alu_muldiv_unit: directed and randomized checks of alu_muldiv_unit against an arithmetic model
module tb_alu_muldiv_unit;
    import mips_pkg::*;
    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_valid = 1'b0, i_flush = 1'b0;
    logic [5:0]  i_func = '0;
    logic [31:0] i_rs = '0, i_rt = '0;
    logic        o_busy, o_stall, o_done;
    logic [31:0] o_hi, o_lo;
    int          total = 0, bad = 0;

    always #5 i_clk = ~i_clk;

    alu_muldiv_unit #(.DATA_W(32), .FUNC_W(6)) dut (
        .i_clk  (i_clk),
        .i_rst_n(i_rst_n),
        .i_valid(i_valid),
        .i_func (i_func),
        .i_rs   (i_rs),
        .i_rt   (i_rt),
        .i_flush(i_flush),
        .o_busy (o_busy),
        .o_stall(o_stall),
        .o_done (o_done),
        .o_hi   (o_hi),
        .o_lo   (o_lo)
    );

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // {HI,LO} from plain 64-bit arithmetic
    function automatic logic [63:0] model(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        longint          sa = longint'($signed(a));
        longint          sb = longint'($signed(b));
        longint unsigned ua = 64'(a);
        longint unsigned ub = 64'(b);
        longint          q, r;
        if (f == FN_MULT) return sa * sb;
        if (f == FN_MULTU) return ua * ub;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (f == FN_DIV) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            5: return 32'($urandom_range(0, 20)) - 32'd10;
            default: return $urandom;
        endcase
    endfunction

    task automatic start_op(logic [5:0] f, logic [31:0] a, logic [31:0] b);
        i_valid = 1'b1;
        i_func  = f;
        i_rs    = a;
        i_rt    = b;
        @(posedge i_clk);
        #1 i_valid = 1'b0;
    endtask

    task automatic finish_op(string tag, logic [63:0] exp, logic st);
        int   n    = 0;
        logic seen = 1'b0;
        while (!seen && n < 100) begin
            @(negedge i_clk);
            n++;
            if (n == 1) begin
                chk({tag, " busy1"}, 64'(o_busy), 64'd1);
                chk({tag, " stall1"}, 64'(o_stall), 64'(st));
            end
            seen = o_done;
        end
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " stall_fix"}, 64'(o_stall), 64'(st));
        @(posedge i_clk);
        #1;
        chk({tag, " busy_end"}, 64'(o_busy), 64'd0);
        chk({tag, " stall_end"}, 64'(o_stall), 64'd0);
        chk({tag, " hilo"}, {o_hi, o_lo}, exp);
    endtask

    initial begin
        int   n;
        logic seen;
        logic [5:0]  f;
        logic [31:0] a, b, v;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset hilo", {o_hi, o_lo}, 64'd0);
        chk("reset flags", {61'd0, o_busy, o_stall, o_done}, 64'd0);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        start_op(FN_MULT, 32'd7, -32'sd3);
        finish_op("mult7x-3", 64'hFFFFFFFF_FFFFFFEB, 1'b0);
        start_op(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        finish_op("multu_max", 64'hFFFFFFFE_00000001, 1'b0);
        start_op(FN_DIV, -32'sd7, 32'd2);
        finish_op("div-7/2", 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        start_op(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        finish_op("div_ovf", 64'h00000000_80000000, 1'b0);
        start_op(FN_DIVU, 32'd7, 32'd0);
        finish_op("divu_by0", 64'h00000007_FFFFFFFF, 1'b0);
        start_op(FN_DIV, -32'sd9, 32'd0);
        finish_op("div_neg_by0", 64'hFFFFFFF7_FFFFFFFF, 1'b0);

        // MFHI stalls behind an in-flight MULT and then sees the new HI
        start_op(FN_MTHI, 32'd1234, 32'd0);
        chk("mthi", 64'(o_hi), 64'd1234);
        start_op(FN_MULT, 32'd7, -32'sd3);
        i_valid = 1'b1;
        i_func  = FN_MFHI;
        finish_op("mfhi_stall", 64'hFFFFFFFF_FFFFFFEB, 1'b1);
        chk("mfhi_value", 64'(o_hi), 64'hFFFFFFFF);
        i_valid = 1'b0;

        // a start presented during FIX waits for the following IDLE cycle
        start_op(FN_MULTU, 32'd3, 32'd5);
        n = 0;
        while (!o_done && n < 100) begin
            @(negedge i_clk);
            n++;
        end
        chk("coll latency", 64'(n), 64'd33);
        i_valid = 1'b1;
        i_func  = FN_MULT;
        i_rs    = -32'sd2;
        i_rt    = 32'd9;
        #1 chk("coll stall_fix", 64'(o_stall), 64'd1);
        @(posedge i_clk);
        #1;
        chk("coll idle", 64'(o_busy), 64'd0);
        chk("coll first", {o_hi, o_lo}, 64'd15);
        @(posedge i_clk);
        #1 i_valid = 1'b0;
        finish_op("coll second", model(FN_MULT, -32'sd2, 32'd9), 1'b0);

        // flush in IDLE blocks acceptance
        i_valid = 1'b1;
        i_func  = FN_MULT;
        i_flush = 1'b1;
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        i_flush = 1'b0;
        chk("flush_idle busy", 64'(o_busy), 64'd0);

        // flush mid-divide keeps the old HI/LO and suppresses o_done
        start_op(FN_MTHI, 32'hA5A5, 32'd0);
        start_op(FN_MTLO, 32'h5A5A, 32'd0);
        start_op(FN_DIV, 32'd100, 32'd7);
        seen = 1'b0;
        repeat (10) begin
            @(negedge i_clk);
            seen |= o_done;
        end
        i_flush = 1'b1;
        @(posedge i_clk);
        #1 i_flush = 1'b0;
        chk("flush busy", 64'(o_busy), 64'd0);
        repeat (40) begin
            @(negedge i_clk);
            seen |= o_done;
        end
        chk("flush no_done", 64'(seen), 64'd0);
        chk("flush hilo", {o_hi, o_lo}, 64'h0000A5A5_00005A5A);

        // async reset mid-divide clears HI/LO at once
        start_op(FN_DIV, 32'd100, 32'd7);
        repeat (5) @(negedge i_clk);
        i_rst_n = 1'b0;
        #1;
        chk("rst_mid hilo", {o_hi, o_lo}, 64'd0);
        chk("rst_mid busy", 64'(o_busy), 64'd0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int i = 0; i < 30; i++) begin
            f = FN_MULT + 6'($urandom_range(0, 3));
            a = pick();
            b = pick();
            start_op(f, a, b);
            finish_op($sformatf("rnd%0d f=%b a=%h b=%h", i, f, a, b), model(f, a, b), 1'b0);
            v = $urandom;
            start_op(FN_MTLO, v, 32'd0);
            chk($sformatf("rnd%0d mtlo", i), 64'(o_lo), 64'(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
